// File: rtl/riscv64g_mem_arb.sv
// Two-port (instruction fetch / data memory) arbiter onto a single memory
// command channel. It keeps one transaction outstanding, uses round-robin
// on ties, and completes with an error after TIMEOUT cycles of silence.
module riscv64g_mem_arb #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RSTn,
  // instruction fetch port
  input  logic              IF_REQ,
  input  logic [XLEN-1:0]   IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [XLEN-1:0]   IF_RDATA,
  output logic              IF_ERR,
  // data memory port
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [XLEN-1:0]   DM_ADDR,
  input  logic [XLEN-1:0]   DM_WDATA,
  input  logic [XLEN/8-1:0] DM_BE,
  output logic              DM_GNT,
  output logic              DM_RVALID,
  output logic [XLEN-1:0]   DM_RDATA,
  output logic              DM_ERR,
  // shared memory command / response
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [XLEN-1:0]   MEM_ADDR,
  output logic [XLEN-1:0]   MEM_WDATA,
  output logic [XLEN/8-1:0] MEM_BE,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [XLEN-1:0]   MEM_RDATA
);

  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  // latched command and ownership
  logic            cmd_we;
  logic [XLEN-1:0] cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic [BW-1:0]   cmd_be;
  logic            owner_dm;
  logic            last_dm;
  logic [CW-1:0]   tmo_cnt;

  logic            grant_pend;
  logic            grant;
  logic            pick_dm;
  logic            mem_done;
  logic            tmo_hit;
  logic            tmo_err;
  logic            finish;

  logic            if_gnt_d;
  logic            dm_gnt_d;
  logic            if_rvalid_d;
  logic            dm_rvalid_d;
  logic            err_d;
  logic [XLEN-1:0] rdata_d;

  // A registered grant pulse means the command is already latched; the
  // FSM moves to ISSUE in the cycle after the pulse is visible.
  assign grant_pend = IF_GNT | DM_GNT;
  assign grant      = (state_q == S_IDLE) && !grant_pend && (IF_REQ || DM_REQ);
  assign pick_dm    = DM_REQ && (!IF_REQ || !last_dm);
  assign mem_done   = MEM_RVALID &&
                      ((state_q == S_WAIT) || ((state_q == S_ISSUE) && MEM_GNT));
  // counter reads k in the k-th cycle after ISSUE entry, so the error
  // completion becomes visible exactly TIMEOUT cycles after entry
  assign tmo_hit    = (state_q != S_IDLE) &&
                      ((17'(tmo_cnt) + 17'd1) == 17'(TIMEOUT));
  assign tmo_err    = tmo_hit && !mem_done;
  assign finish     = mem_done || tmo_hit;

  // memory command comes straight from the command register
  assign MEM_REQ   = (state_q == S_ISSUE);
  assign MEM_WE    = cmd_we;
  assign MEM_ADDR  = cmd_addr;
  assign MEM_WDATA = cmd_wdata;
  assign MEM_BE    = cmd_be;

  // state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_pend) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (finish)       state_d = S_IDLE;
        else if (MEM_GNT) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // next values of the registered requester-side outputs
  always_comb begin
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    if (grant) begin
      if_gnt_d = !pick_dm;
      dm_gnt_d = pick_dm;
    end
    if (finish) begin
      if_rvalid_d = !owner_dm;
      dm_rvalid_d = owner_dm;
      err_d       = tmo_err;
      if (mem_done && !cmd_we) rdata_d = MEM_RDATA;
    end
  end

  // output registers, command register, arbitration pointer, timeout counter
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      IF_GNT    <= 1'b0;
      IF_RVALID <= 1'b0;
      IF_RDATA  <= '0;
      IF_ERR    <= 1'b0;
      DM_GNT    <= 1'b0;
      DM_RVALID <= 1'b0;
      DM_RDATA  <= '0;
      DM_ERR    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
      owner_dm  <= 1'b0;
      last_dm   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      IF_GNT    <= if_gnt_d;
      DM_GNT    <= dm_gnt_d;
      IF_RVALID <= if_rvalid_d;
      DM_RVALID <= dm_rvalid_d;
      IF_ERR    <= if_rvalid_d & err_d;
      DM_ERR    <= dm_rvalid_d & err_d;
      IF_RDATA  <= if_rvalid_d ? rdata_d : '0;
      DM_RDATA  <= dm_rvalid_d ? rdata_d : '0;
      if (grant) begin
        owner_dm <= pick_dm;
        last_dm  <= pick_dm;
        if (pick_dm) begin
          cmd_we    <= DM_WE;
          cmd_addr  <= DM_ADDR;
          cmd_wdata <= DM_WDATA;
          cmd_be    <= DM_BE;
        end else begin
          cmd_we    <= 1'b0;
          cmd_addr  <= IF_ADDR;
          cmd_wdata <= '0;
          cmd_be    <= '1;
        end
      end
      if (state_q == S_IDLE) tmo_cnt <= '0;
      else                   tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_riscv64g_mem_arb.sv
// Bench for riscv64g_mem_arb: directed vector table, hand-written multi-cycle
// corner cases (timeout, coincident timeout, reset mid-transaction) and a
// randomized transaction stream against a transaction-level model.
module tb_riscv64g_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [63:0] if_addr, dm_addr, dm_wdata;
  logic [7:0]  dm_be;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  logic        if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err;
  logic [63:0] if_rdata, dm_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;

  logic        t_if_gnt, t_if_rvalid, t_if_err, t_dm_gnt, t_dm_rvalid, t_dm_err;
  logic [63:0] t_if_rdata, t_dm_rdata;
  logic        t_mem_req, t_mem_we;
  logic [63:0] t_mem_addr, t_mem_wdata;
  logic [7:0]  t_mem_be;

  riscv64g_mem_arb u_dut (
    .CLK(clk), .RSTn(rst_n),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt), .IF_RVALID(if_rvalid),
    .IF_RDATA(if_rdata), .IF_ERR(if_err),
    .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata), .DM_BE(dm_be),
    .DM_GNT(dm_gnt), .DM_RVALID(dm_rvalid), .DM_RDATA(dm_rdata), .DM_ERR(dm_err),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_BE(mem_be), .MEM_GNT(mem_gnt), .MEM_RVALID(mem_rvalid), .MEM_RDATA(mem_rdata)
  );

  riscv64g_mem_arb #(.XLEN(64), .TIMEOUT(4)) u_to (
    .CLK(clk), .RSTn(rst_n),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(t_if_gnt), .IF_RVALID(t_if_rvalid),
    .IF_RDATA(t_if_rdata), .IF_ERR(t_if_err),
    .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata), .DM_BE(dm_be),
    .DM_GNT(t_dm_gnt), .DM_RVALID(t_dm_rvalid), .DM_RDATA(t_dm_rdata), .DM_ERR(t_dm_err),
    .MEM_REQ(t_mem_req), .MEM_WE(t_mem_we), .MEM_ADDR(t_mem_addr), .MEM_WDATA(t_mem_wdata),
    .MEM_BE(t_mem_be), .MEM_GNT(mem_gnt), .MEM_RVALID(mem_rvalid), .MEM_RDATA(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [63:0] iaddr;
    logic [63:0] daddr;
    logic [63:0] dwdata;
    logic [7:0]  dbe;
    int          gd;
    int          rd;
    logic [63:0] rdata;
    logic        exp_dm;
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_be;
    logic [63:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic vec_t mk(input logic ireq, input logic dreq, input logic dwe,
                              input logic [63:0] iaddr, input logic [63:0] daddr,
                              input logic [63:0] dwdata, input logic [7:0] dbe,
                              input int gd, input int rd, input logic [63:0] rdata,
                              input logic exp_dm, input logic exp_we,
                              input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                              input logic [7:0] exp_be, input logic [63:0] exp_rdata);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.iaddr = iaddr; v.daddr = daddr;
    v.dwdata = dwdata; v.dbe = dbe; v.gd = gd; v.rd = rd; v.rdata = rdata;
    v.exp_dm = exp_dm; v.exp_we = exp_we; v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata; v.exp_be = exp_be; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
    chk1({tag, "_dm_gnt"}, dm_gnt, 1'b0);
    chk1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    chk1({tag, "_dm_rvalid"}, dm_rvalid, 1'b0);
    chk1({tag, "_if_err"}, if_err, 1'b0);
    chk1({tag, "_dm_err"}, dm_err, 1'b0);
    chk({tag, "_if_rdata"}, if_rdata, 64'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 64'h0);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 64'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    chk({tag, "_mem_be"}, 64'(mem_be), 64'h0);
  endtask

  task automatic chk_cmd(input vec_t v);
    chk1("mem_req", mem_req, 1'b1);
    chk1("mem_we", mem_we, v.exp_we);
    chk("mem_addr", mem_addr, v.exp_addr);
    chk("mem_wdata", mem_wdata, v.exp_wdata);
    chk("mem_be", 64'(mem_be), 64'(v.exp_be));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // one complete transaction: request, grant, command hold, response
  task automatic run_txn(input vec_t v);
    if_req = v.ireq; if_addr = v.iaddr;
    dm_req = v.dreq; dm_we = v.dwe; dm_addr = v.daddr; dm_wdata = v.dwdata; dm_be = v.dbe;
    tick();
    chk1("dm_gnt", dm_gnt, v.exp_dm);
    chk1("if_gnt", if_gnt, !v.exp_dm);
    chk1("mem_req_gnt_cycle", mem_req, 1'b0);
    if (v.exp_dm) dm_req = 1'b0;
    else          if_req = 1'b0;
    tick();
    chk_cmd(v);
    for (int i = 0; i < v.gd; i++) begin
      mem_gnt = 1'b0;
      mem_rvalid = (i % 2 == 0);
      mem_rdata = rnd64();
      tick();
      chk_cmd(v);
      chk1("rvalid_before_mem_gnt", if_rvalid | dm_rvalid, 1'b0);
    end
    mem_gnt = 1'b1;
    mem_rvalid = (v.rd == 0);
    mem_rdata = v.rdata;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (v.rd > 0) begin
      chk1("mem_req_wait", mem_req, 1'b0);
      for (int j = 1; j < v.rd; j++) begin
        tick();
        chk1("rvalid_early", if_rvalid | dm_rvalid, 1'b0);
      end
      mem_rvalid = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_rvalid = 1'b0;
    end
    chk1("owner_rvalid", v.exp_dm ? dm_rvalid : if_rvalid, 1'b1);
    chk1("other_rvalid", v.exp_dm ? if_rvalid : dm_rvalid, 1'b0);
    chk1("owner_err", v.exp_dm ? dm_err : if_err, 1'b0);
    chk("owner_rdata", v.exp_dm ? dm_rdata : if_rdata, v.exp_rdata);
  endtask

  vec_t        tbl [10];
  vec_t        rv;
  logic        m_last_dm, p_if, p_dm, p_dwe;
  logic [63:0] p_iaddr, p_daddr, p_dwdata;
  logic [7:0]  p_dbe;

  initial begin
    tbl[0] = mk(1'b1, 1'b1, 1'b0, 64'h8000_0000, 64'h8000_0010, 64'h0, 8'hFF, 0, 2, 64'h1122,
                1'b1, 1'b0, 64'h8000_0010, 64'h0, 8'hFF, 64'h1122);
    tbl[1] = mk(1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 0, 1, 64'h3344,
                1'b0, 1'b0, 64'h8000_0000, 64'h0, 8'hFF, 64'h3344);
    tbl[2] = mk(1'b0, 1'b1, 1'b1, 64'h0, 64'h100, 64'hAB, 8'h01, 2, 0, 64'hDEAD_BEEF,
                1'b1, 1'b1, 64'h100, 64'hAB, 8'h01, 64'h0);
    tbl[3] = mk(1'b1, 1'b0, 1'b0, 64'h8000_0040, 64'h0, 64'h0, 8'h00, 5, 3, 64'h5566,
                1'b0, 1'b0, 64'h8000_0040, 64'h0, 8'hFF, 64'h5566);
    for (int i = 0; i < 6; i++) begin
      tbl[4+i] = mk(1'b1, 1'b1, 1'b0, 64'h1000 + 64'(4*i), 64'h2000 + 64'(8*i), 64'h77, 8'h0F,
                    i % 3, (i + 1) % 4, 64'hA000 + 64'(i),
                    (i % 2 == 0), 1'b0,
                    (i % 2 == 0) ? 64'h2000 + 64'(8*i) : 64'h1000 + 64'(4*i),
                    (i % 2 == 0) ? 64'h77 : 64'h0,
                    (i % 2 == 0) ? 8'h0F : 8'hFF, 64'hA000 + 64'(i));
    end

    // reset values, with a request pending to prove grants are suppressed
    do_reset();
    rst_n = 1'b0;
    if_req = 1'b1;
    tick();
    chk_idle_outputs("reset");
    chk1("reset_t_mem_req", t_mem_req, 1'b0);
    if_req = 1'b0;
    rst_n = 1'b1;

    // stray memory response while idle
    mem_rvalid = 1'b1;
    mem_rdata = 64'h1234;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk_idle_outputs("idle_stray_rvalid");

    // directed vector table
    for (int k = 0; k < 10; k++) run_txn(tbl[k]);

    // timeout with TIMEOUT=4; the default instance keeps waiting until 255
    do_reset();
    if_req = 1'b1;
    if_addr = 64'h4000;
    tick();
    chk1("to_if_gnt", t_if_gnt, 1'b1);
    if_req = 1'b0;
    tick();
    chk1("to_mem_req", t_mem_req, 1'b1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk1("to_rvalid_early", t_if_rvalid, 1'b0);
    end
    tick();
    chk1("to_rvalid", t_if_rvalid, 1'b1);
    chk1("to_err", t_if_err, 1'b1);
    chk("to_rdata", t_if_rdata, 64'h0);
    chk1("to_mem_req_after", t_mem_req, 1'b0);
    chk1("to_dm_rvalid", t_dm_rvalid, 1'b0);
    chk1("to_default_still_issuing", mem_req, 1'b1);
    tick();
    chk1("to_rvalid_pulse", t_if_rvalid, 1'b0);
    chk1("to_idle", t_mem_req, 1'b0);
    for (int k = 0; k < 249; k++) tick();
    chk1("to255_rvalid_early", if_rvalid, 1'b0);
    tick();
    chk1("to255_rvalid", if_rvalid, 1'b1);
    chk1("to255_err", if_err, 1'b1);
    chk("to255_rdata", if_rdata, 64'h0);

    // completion landing on the timeout cycle is a normal completion
    if_req = 1'b1;
    if_addr = 64'h4100;
    tick();
    chk1("co_if_gnt", t_if_gnt, 1'b1);
    if_req = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 64'hC0FFEE;
    tick();
    mem_rvalid = 1'b0;
    chk1("co_rvalid", t_if_rvalid, 1'b1);
    chk1("co_err", t_if_err, 1'b0);
    chk("co_rdata", t_if_rdata, 64'hC0FFEE);

    // reset during WAIT abandons the transaction
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h300;
    tick();
    chk1("rw_dm_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rw_async");
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 64'hBAD;
    tick();
    mem_rvalid = 1'b0;
    chk1("rw_no_dm_rvalid", dm_rvalid, 1'b0);
    chk1("rw_no_if_rvalid", if_rvalid, 1'b0);
    if_req = 1'b1; if_addr = 64'h500;
    dm_req = 1'b1; dm_addr = 64'h600;
    tick();
    chk1("rw_tie_dm_gnt", dm_gnt, 1'b1);
    chk1("rw_tie_if_gnt", if_gnt, 1'b0);

    // randomized transactions against a transaction-level model
    do_reset();
    m_last_dm = 1'b0;
    p_if = 1'b0; p_dm = 1'b0;
    p_dwe = 1'b0; p_iaddr = '0; p_daddr = '0; p_dwdata = '0; p_dbe = '0;
    for (int n = 0; n < 150; n++) begin
      if (!p_if && ($urandom_range(0, 1) == 1)) begin
        p_if = 1'b1;
        p_iaddr = rnd64();
      end
      if (!p_dm && ($urandom_range(0, 1) == 1)) begin
        p_dm = 1'b1;
        p_dwe = 1'($urandom_range(0, 1));
        p_daddr = rnd64();
        p_dwdata = rnd64();
        p_dbe = 8'($urandom_range(0, 255));
      end
      if (!p_if && !p_dm) begin
        p_if = 1'b1;
        p_iaddr = rnd64();
      end
      rv.ireq = p_if; rv.dreq = p_dm; rv.dwe = p_dwe;
      rv.iaddr = p_iaddr; rv.daddr = p_daddr; rv.dwdata = p_dwdata; rv.dbe = p_dbe;
      rv.gd = int'($urandom_range(0, 3));
      rv.rd = int'($urandom_range(0, 3));
      rv.rdata = rnd64();
      rv.exp_dm = p_dm && (!p_if || !m_last_dm);
      rv.exp_we = rv.exp_dm ? p_dwe : 1'b0;
      rv.exp_addr = rv.exp_dm ? p_daddr : p_iaddr;
      rv.exp_wdata = rv.exp_dm ? p_dwdata : 64'h0;
      rv.exp_be = rv.exp_dm ? p_dbe : 8'hFF;
      rv.exp_rdata = (rv.exp_dm && p_dwe) ? 64'h0 : rv.rdata;
      run_txn(rv);
      m_last_dm = rv.exp_dm;
      if (rv.exp_dm) p_dm = 1'b0;
      else           p_if = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
